// File: rtl/vedic_div8x4_if.sv
// vedic_div8x4_if
// Handshake and data bundle for the sequential restoring divider.
//   start, dividend, divisor           : request side, driven by the master
//   busy, done, quotient, remainder,
//   div_zero                           : status/result side, driven by the divider
// Modports:
//   master : the requester (drives start/operands, observes results)
//   slave  : the divider itself
interface vedic_div8x4_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/vedic_div8x4.sv
// vedic_div8x4
// Sequential unsigned restoring divider, the inverse of the 4x4 Vedic
// multiplier: DW-bit dividend / VW-bit divisor -> DW-bit quotient and
// VW-bit remainder, one quotient bit per clock.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset; aborts any operation in flight
//   bus    : vedic_div8x4_if.slave (start/dividend/divisor in,
//            busy/done/quotient/remainder/div_zero out, all registered)
// A request is accepted in IDLE or DONE. A zero divisor skips RUN and
// goes straight to DONE with an all-ones quotient and div_zero set.
module vedic_div8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    vedic_div8x4_if.slave  bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] q_reg;          // dividend shifting out, quotient shifting in
    logic [VW-1:0] d_reg;          // latched divisor
    logic [VW-1:0] r_reg;          // partial remainder (its extra top bit is always 0 between steps)
    logic [CW-1:0] count_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [DW-1:0] quotient_reg;
    logic [VW-1:0] remainder_reg;
    logic          div_zero_reg;

    // One restoring step: bring the next dividend bit into the remainder,
    // trial-subtract the divisor, keep the difference when it fits.
    logic [VW:0]   trial;
    logic          fits;
    logic [VW-1:0] diff;
    logic [VW-1:0] r_next;
    logic [DW-1:0] q_next;

    assign trial  = {r_reg, q_reg[DW-1]};
    assign fits   = (trial >= {1'b0, d_reg});
    // When the subtract is taken the result is below the divisor, so the
    // low VW bits of the difference are the whole answer.
    assign diff   = trial[VW-1:0] - d_reg;
    assign r_next = fits ? diff : trial[VW-1:0];

    assign q_next[0] = fits;
    generate
        for (genvar gi = 1; gi < DW; gi++) begin : g_qshift
            assign q_next[gi] = q_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            q_reg        <= bus.dividend;
                            d_reg        <= bus.divisor;
                            r_reg        <= '0;
                            count_reg    <= '0;
                            div_zero_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                            done_reg     <= 1'b0;
                            state_reg    <= RUN;
                        end else begin
                            quotient_reg  <= '1;
                            remainder_reg <= '0;
                            div_zero_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end else begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here
                    q_reg     <= q_next;
                    r_reg     <= r_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(DW - 1)) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
endmodule

// File: tb/tb_vedic_div8x4.sv
// tb_vedic_div8x4
// Self-checking bench for vedic_div8x4. Expected results are pushed to a
// scoreboard queue when a request is driven and popped when done is seen.
module tb_vedic_div8x4;
    logic clk;
    logic rst_n;

    vedic_div8x4_if #(.DW(8), .VW(4)) bus ();

    vedic_div8x4 #(.DW(8), .VW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
        int         busy_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Urdhva-tiryagbhyam (vertically and crosswise) 4x4 product.
    function automatic logic [7:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
        int col;
        int carry;
        logic [7:0] p;
        carry = 0;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            col = carry;
            for (int i = 0; i < 4; i++) begin
                int j;
                j = k - i;
                if (j >= 0 && j < 4) col += int'(a[i] & b[j]);
            end
            p[k]  = col[0];
            carry = col >> 1;
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse (one edge) and record the expected outcome.
    task automatic drive_start(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1; e.lat = 0; e.busy_cyc = 0;
        end else begin
            e.q = a / {4'd0, b};
            e.r = 4'(a % {4'd0, b});
            e.dz = 1'b0; e.lat = 8; e.busy_cyc = 8;
        end
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        step();
        bus.start = 1'b0;
    endtask

    // Bounded wait for done; counts edges after acceptance and busy samples.
    task automatic wait_done(output int lat, output int busy_cyc, output bit timed_out);
        lat = 0; busy_cyc = 0; timed_out = 1'b0;
        while (bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (lat >= 20) begin
                timed_out = 1'b1;
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.dividend = 8'd5; bus.divisor = 4'd0;  // reset must win
        step();
        step();
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done got done=%b want 0", bus.done);
        end
        $display("reset: outputs cleared");
    endtask

    task automatic test_basic();
        int lat, bc; bit to; exp_t e;
        drive_start(8'd200, 4'd7);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || lat != e.lat || bc != e.busy_cyc) begin
            failures++;
            $display("FAIL basic_timing got lat=%0d busy=%0d timeout=%0b want lat=%0d busy=%0d",
                     lat, bc, to, e.lat, e.busy_cyc);
        end
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     bus.quotient, bus.remainder, bus.div_zero, e.q, e.r, e.dz);
        end
        $display("basic: 200/7 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.quotient !== e.q || bus.remainder !== e.r) begin
            failures++;
            $display("FAIL basic_done_one_cycle got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                     bus.done, bus.quotient, bus.remainder, e.q, e.r);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] av [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
        logic [3:0] bv [4] = '{4'd1, 4'd15, 4'd9, 4'd3};
        int lat, bc; bit to; exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_start(av[i], bv[i]);
            wait_done(lat, bc, to);
            e = sb.pop_front();
            checks++;
            if (to || lat != e.lat ||
                {bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
                failures++;
                $display("FAIL boundary_%0d/%0d got q=%0d r=%0d dz=%b lat=%0d want q=%0d r=%0d dz=%b lat=%0d",
                         av[i], bv[i], bus.quotient, bus.remainder, bus.div_zero, lat,
                         e.q, e.r, e.dz, e.lat);
            end
            $display("boundary: %0d/%0d -> q=%0d r=%0d", av[i], bv[i], bus.quotient, bus.remainder);
        end
        step();
    endtask

    task automatic test_div_zero();
        int lat, bc; bit to; exp_t e;
        drive_start(8'd77, 4'd0);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || lat != 0 || bc != 0) begin
            failures++;
            $display("FAIL divzero_timing got lat=%0d busy=%0d timeout=%0b want lat=0 busy=0", lat, bc, to);
        end
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
            failures++;
            $display("FAIL divzero_result got q=%h r=%0d dz=%b want q=%h r=%0d dz=%b",
                     bus.quotient, bus.remainder, bus.div_zero, e.q, e.r, e.dz);
        end
        $display("divzero: 77/0 -> q=%h r=%0d dz=%b", bus.quotient, bus.remainder, bus.div_zero);
        step();
        drive_start(8'd77, 4'd7);
        checks++;
        if (bus.div_zero !== 1'b0) begin
            failures++;
            $display("FAIL divzero_clear_at_start got dz=%b want 0", bus.div_zero);
        end
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || {bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
            failures++;
            $display("FAIL divzero_followup got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     bus.quotient, bus.remainder, bus.div_zero, e.q, e.r, e.dz);
        end
        $display("divzero: 77/7 -> q=%0d r=%0d dz=%b", bus.quotient, bus.remainder, bus.div_zero);
        step();
    endtask

    task automatic test_start_held();
        int lat, bc; bit to; exp_t e;
        e.q = 8'd28; e.r = 4'd4; e.dz = 1'b0; e.lat = 8; e.busy_cyc = 8;
        sb.push_back(e);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
        step();
        bus.dividend = 8'd13; bus.divisor = 4'd2;  // must not be picked up
        wait_done(lat, bc, to);
        bus.start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (to || lat != e.lat ||
            {bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
            failures++;
            $display("FAIL start_held got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                     bus.quotient, bus.remainder, lat, e.q, e.r, e.lat);
        end
        $display("start_held: 200/7 -> q=%0d r=%0d", bus.quotient, bus.remainder);
        step();
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit to; exp_t e;
        drive_start(8'd50, 4'd6);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || {bus.quotient, bus.remainder} !== {e.q, e.r}) begin
            failures++;
            $display("FAIL b2b_first got q=%0d r=%0d want q=%0d r=%0d", bus.quotient, bus.remainder, e.q, e.r);
        end
        drive_start(8'd100, 4'd10);  // issued in the done cycle
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || lat != 8 || {bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
            failures++;
            $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=8",
                     bus.quotient, bus.remainder, lat, e.q, e.r);
        end
        $display("back_to_back: 100/10 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
        step();
    endtask

    task automatic test_reset_mid();
        int lat, bc; bit to; exp_t e; int seen_done;
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
        step();                      // E0
        bus.start = 1'b0;
        step(); step(); step();      // E1..E3
        rst_n = 1'b0;
        step();                      // E4 with reset
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero} !== 15'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero);
        end
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen_done);
        end
        drive_start(8'd9, 4'd2);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || {bus.quotient, bus.remainder, bus.div_zero} !== {e.q, e.r, e.dz}) begin
            failures++;
            $display("FAIL reset_mid_after got q=%0d r=%0d want q=%0d r=%0d", bus.quotient, bus.remainder, e.q, e.r);
        end
        $display("reset_mid: aborted, then 9/2 -> q=%0d r=%0d", bus.quotient, bus.remainder);
        step();
    endtask

    task automatic test_inverse();
        int lat, bc; bit to; exp_t e; int bad;
        bad = 0;
        for (int a = 1; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                drive_start(vedic4x4(4'(a), 4'(b)), 4'(b));
                wait_done(lat, bc, to);
                e = sb.pop_front();
                checks++;
                if (to || bus.quotient !== 8'(a) || bus.remainder !== 4'd0 || bus.div_zero !== 1'b0) begin
                    failures++; bad++;
                    $display("FAIL inverse_%0dx%0d got q=%0d r=%0d want q=%0d r=0",
                             a, b, bus.quotient, bus.remainder, a);
                end
            end
        end
        step();
        $display("inverse: 225 vedic4x4 products divided back, %0d bad", bad);
    endtask

    task automatic test_exhaustive();
        int lat, bc; bit to; exp_t e; int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                drive_start(8'(a), 4'(b));
                wait_done(lat, bc, to);
                e = sb.pop_front();
                checks++;
                if (to || int'(bus.quotient) * b + int'(bus.remainder) != a ||
                    int'(bus.remainder) >= b ||
                    {bus.quotient, bus.remainder} !== {e.q, e.r}) begin
                    failures++; bad++;
                    $display("FAIL exhaustive_%0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                             a, b, bus.quotient, bus.remainder, e.q, e.r);
                end
            end
        end
        step();
        $display("exhaustive: 3840 nonzero-divisor pairs, %0d bad", bad);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_inverse();
        test_exhaustive();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
